// File: rtl/pipe_y_store_pkg.sv
// pipe_y_store_pkg: shared types and constants for the pipe gap-Y store.
// Holds state encoding, pipe count, coordinate width, gap table, LFSR taps.
package pipe_y_store_pkg;

    localparam int NPIPE = 4;
    localparam int YW    = 10;

    // One-hot, packed as {Q_Stop, Q_Count, Q_Initial}.
    typedef enum logic [2:0] {
        QInitial = 3'b001,
        QCount   = 3'b010,
        QStop    = 3'b100
    } state_t;

    // Gap offsets used when the LFSR is not built; entry 0 in the low byte.
    localparam logic [63:0] GAP_TABLE = {
        8'd140, 8'd100, 8'd200, 8'd60,
        8'd160, 8'd80,  8'd120, 8'd40
    };

    // Fibonacci taps 8,6,5,4 on an 8-bit register.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/pipe_y_store_if.sv
// pipe_y_store_if: control/index inputs and gap-Y outputs of pipe_y_store.
// master drives Start/Stop/Ack/pipe_idx; slave drives Y outputs, Regen, flags.
interface pipe_y_store_if;
    import pipe_y_store_pkg::*;

    logic          Start;
    logic          Stop;
    logic          Ack;
    logic [1:0]    pipe_idx;
    logic [YW-1:0] Y_Out;
    logic [YW-1:0] Y_Edge_O1;
    logic [YW-1:0] Y_Edge_O2;
    logic [YW-1:0] Y_Edge_O3;
    logic          Regen;
    logic          Q_Initial;
    logic          Q_Count;
    logic          Q_Stop;

    modport master (
        output Start, Stop, Ack, pipe_idx,
        input  Y_Out, Y_Edge_O1, Y_Edge_O2, Y_Edge_O3,
        input  Regen, Q_Initial, Q_Count, Q_Stop
    );

    modport slave (
        input  Start, Stop, Ack, pipe_idx,
        output Y_Out, Y_Edge_O1, Y_Edge_O2, Y_Edge_O3,
        output Regen, Q_Initial, Q_Count, Q_Stop
    );

endinterface

// File: rtl/pipe_y_lfsr.sv
// pipe_y_lfsr: 8-bit Fibonacci LFSR (taps 8,6,5,4) with seed load and enable.
// Ports: clk, reset (sync, high), i_load (reload seed), i_en (step), o_q (value).
module pipe_y_lfsr
    import pipe_y_store_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_load,
    input  logic       i_en,
    output logic [7:0] o_q
);

    // An all-zero register would lock up, so a zero seed becomes 1.
    localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

    logic [7:0] r_q;
    logic       w_fb;

    assign w_fb = ^(r_q & LFSR_TAPS);
    assign o_q  = r_q;

    always_ff @(posedge clk) begin
        if (reset || i_load) begin
            r_q <= SEED_EFF;
        end else if (i_en) begin
            r_q <= {r_q[6:0], w_fb};
        end
    end

endmodule

// File: rtl/pipe_y_store.sv
// pipe_y_store: per-pipe gap-centre Y store, rewriting a pipe as it leaves scope.
// Ports: clk, reset (sync, high); bus (slave): Start/Stop/Ack, pipe_idx in;
// Y_Out, Y_Edge_O1..O3, Regen, Q_Initial/Q_Count/Q_Stop out.
// Macro PIPE_Y_LFSR_EN: gap source is an LFSR instead of the fixed gap table.
module pipe_y_store
    import pipe_y_store_pkg::*;
#(
    parameter int         Y0_INIT   = 120,
    parameter int         Y1_INIT   = 200,
    parameter int         Y2_INIT   = 160,
    parameter int         Y3_INIT   = 240,
    parameter int         Y_MIN     = 60,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input logic            clk,
    input logic            reset,
    pipe_y_store_if.slave  bus
);

    state_t        r_state;
    state_t        w_next;
    logic [YW-1:0] r_y [NPIPE];
    logic [1:0]    r_prev;
    logic          r_regen;
    logic          w_change;
    logic          w_write;
    logic [7:0]    w_src8;
    logic [YW-1:0] w_new;

    assign w_change = (bus.pipe_idx != r_prev);
    assign w_write  = (r_state == QCount) && w_change;
    assign w_new    = YW'(Y_MIN) + {2'b00, w_src8};

`ifdef PIPE_Y_LFSR_EN
    logic [7:0] w_lfsr;
    logic       w_lfsr_load;
    logic       w_lfsr_en;

    // Reseed whenever not tracking so every game starts the same sequence.
    assign w_lfsr_load = (r_state != QCount) && (r_state != QStop);
    assign w_lfsr_en   = (r_state == QCount);
    assign w_src8      = w_lfsr;

    pipe_y_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_lfsr_load),
        .i_en   (w_lfsr_en),
        .o_q    (w_lfsr)
    );
`else
    logic [2:0] r_tbl_ptr;
    logic       w_unused_seed;

    assign w_unused_seed = ^LFSR_SEED;
    assign w_src8        = GAP_TABLE[{r_tbl_ptr, 3'b000} +: 8];

    always_ff @(posedge clk) begin
        if (reset || (r_state == QInitial)) begin
            r_tbl_ptr <= 3'd0;
        end else if (w_write) begin
            r_tbl_ptr <= r_tbl_ptr + 3'd1;
        end
    end
`endif

    always_comb begin
        w_next = QInitial;
        case (r_state)
            QInitial: w_next = bus.Start ? QCount : QInitial;
            QCount:   w_next = bus.Stop ? QStop : QCount;
            QStop:    w_next = bus.Ack ? QInitial : QStop;
            default:  w_next = QInitial;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= QInitial;
            r_y[0]  <= YW'(Y0_INIT);
            r_y[1]  <= YW'(Y1_INIT);
            r_y[2]  <= YW'(Y2_INIT);
            r_y[3]  <= YW'(Y3_INIT);
            r_prev  <= 2'd2;
            r_regen <= 1'b0;
        end else begin
            r_state <= w_next;
            r_regen <= 1'b0;
            case (r_state)
                QInitial: begin
                    r_y[0] <= YW'(Y0_INIT);
                    r_y[1] <= YW'(Y1_INIT);
                    r_y[2] <= YW'(Y2_INIT);
                    r_y[3] <= YW'(Y3_INIT);
                    r_prev <= 2'd2;
                end
                QCount: begin
                    // The pipe just left scope re-enters on the right.
                    if (w_change) begin
                        r_y[r_prev] <= w_new;
                        r_prev      <= bus.pipe_idx;
                        r_regen     <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // 2-bit subtraction gives the mod-4 wrap for the trailing pipes.
    assign bus.Y_Out     = r_y[bus.pipe_idx];
    assign bus.Y_Edge_O1 = r_y[bus.pipe_idx - 2'd1];
    assign bus.Y_Edge_O2 = r_y[bus.pipe_idx - 2'd2];
    assign bus.Y_Edge_O3 = r_y[bus.pipe_idx - 2'd3];
    assign bus.Regen     = r_regen;
    assign bus.Q_Initial = r_state[0];
    assign bus.Q_Count   = r_state[1];
    assign bus.Q_Stop    = r_state[2];

endmodule

// File: tb/tb_pipe_y_store.sv
// tb_pipe_y_store: self-checking bench for pipe_y_store against a reference model.
// Honours PIPE_Y_LFSR_EN (then runs the DUT with a zero seed).
module tb_pipe_y_store;

`ifdef PIPE_Y_LFSR_EN
    localparam logic [7:0] TB_SEED = 8'h00;
`else
    localparam logic [7:0] TB_SEED = 8'hA5;
`endif
    localparam int YMIN = 60;
    localparam int INIT_Y [4] = '{120, 200, 160, 240};
    localparam int TABLE [8] = '{40, 120, 80, 160, 60, 200, 100, 140};

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    pipe_y_store_if bus ();

    pipe_y_store #(
        .Y0_INIT   (120),
        .Y1_INIT   (200),
        .Y2_INIT   (160),
        .Y3_INIT   (240),
        .Y_MIN     (YMIN),
        .LFSR_SEED (TB_SEED)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: 0 = initial, 1 = counting, 2 = stopped.
    int m_st;
    int m_y [4];
    int m_prev;
    int m_regen;
    int m_rew;
    int m_lfsr;

    function automatic int lfsr_next(input int v);
        int fb;
        fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
        return ((v << 1) | fb) & 255;
    endfunction

    function automatic int gap_src();
`ifdef PIPE_Y_LFSR_EN
        return m_lfsr;
`else
        return TABLE[m_rew % 8];
`endif
    endfunction

    task automatic model_step();
        int nst;
        if (reset) begin
            m_st = 0;
            for (int i = 0; i < 4; i++) m_y[i] = INIT_Y[i];
            m_prev = 2;
            m_regen = 0;
            m_rew = 0;
            m_lfsr = (TB_SEED == 0) ? 1 : int'(TB_SEED);
            return;
        end
        nst = m_st;
        m_regen = 0;
        if (m_st == 0) begin
            for (int i = 0; i < 4; i++) m_y[i] = INIT_Y[i];
            m_prev = 2;
            m_rew = 0;
            m_lfsr = (TB_SEED == 0) ? 1 : int'(TB_SEED);
            if (bus.Start) nst = 1;
        end else if (m_st == 1) begin
            if (int'(bus.pipe_idx) != m_prev) begin
                m_y[m_prev] = YMIN + gap_src();
                m_prev = int'(bus.pipe_idx);
                m_regen = 1;
                m_rew++;
            end
            m_lfsr = lfsr_next(m_lfsr);
            if (bus.Stop) nst = 2;
        end else begin
            if (bus.Ack) nst = 0;
        end
        m_st = nst;
    endtask

    function automatic logic [43:0] exp_vec();
        int ix;
        ix = int'(bus.pipe_idx);
        return {10'(m_y[ix]), 10'(m_y[(ix + 3) % 4]),
                10'(m_y[(ix + 2) % 4]), 10'(m_y[(ix + 1) % 4]),
                1'(m_regen), (m_st == 2), (m_st == 1), (m_st == 0)};
    endfunction

    function automatic logic [43:0] dut_vec();
        return {bus.Y_Out, bus.Y_Edge_O1, bus.Y_Edge_O2, bus.Y_Edge_O3,
                bus.Regen, bus.Q_Stop, bus.Q_Count, bus.Q_Initial};
    endfunction

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.Start = 1'b0;
        bus.Stop = 1'b0;
        bus.Ack = 1'b0;
        bus.pipe_idx = 2'd2;
        cyc();
        reset = 1'b0;
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL reset_vec got=%h want=%h", dut_vec(), exp_vec());
        end
        n_cmp++;
        if ({bus.Y_Out, bus.Y_Edge_O1, bus.Y_Edge_O2, bus.Y_Edge_O3,
             bus.Q_Initial, bus.Regen} !== {10'd160, 10'd200, 10'd120,
             10'd240, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_const got=%0d/%0d/%0d/%0d qi=%b rg=%b want=160/200/120/240 qi=1 rg=0",
                     bus.Y_Out, bus.Y_Edge_O1, bus.Y_Edge_O2,
                     bus.Y_Edge_O3, bus.Q_Initial, bus.Regen);
        end
    endtask

    task automatic test_regen();
        logic [1:0] seq [4];
        seq = '{2'd2, 2'd3, 2'd3, 2'd0};
        bus.Start = 1'b1;
        cyc();
        bus.Start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.pipe_idx = seq[i];
            cyc();
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL regen_step%0d got=%h want=%h",
                         i, dut_vec(), exp_vec());
            end
`ifndef PIPE_Y_LFSR_EN
            if (i == 1) begin
                n_cmp++;
                if (bus.Y_Edge_O1 !== 10'd100 || bus.Regen !== 1'b1) begin
                    n_bad++;
                    $display("FAIL regen_y2 got=%0d rg=%b want=100 rg=1",
                             bus.Y_Edge_O1, bus.Regen);
                end
            end
            if (i == 3) begin
                n_cmp++;
                if (bus.Y_Edge_O1 !== 10'd180) begin
                    n_bad++;
                    $display("FAIL regen_y3 got=%0d want=180",
                             bus.Y_Edge_O1);
                end
            end
`endif
        end
    endtask

    task automatic test_table_wrap();
        logic [9:0] last;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        bus.Start = 1'b1;
        cyc();
        bus.Start = 1'b0;
        last = '0;
        for (int i = 0; i < 9; i++) begin
            bus.pipe_idx = 2'((3 + i) % 4);
            cyc();
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL wrap_chg%0d got=%h want=%h",
                         i, dut_vec(), exp_vec());
            end
            last = bus.Y_Edge_O1;
        end
`ifndef PIPE_Y_LFSR_EN
        n_cmp++;
        if (last !== 10'd100) begin
            n_bad++;
            $display("FAIL wrap_ninth got=%0d want=100", last);
        end
`endif
    endtask

    task automatic test_stop();
        logic [9:0] frz [4];
        bus.Stop = 1'b1;
        bus.Ack = 1'b1;
        bus.pipe_idx = bus.pipe_idx + 2'd1;
        cyc();
        bus.Stop = 1'b0;
        bus.Ack = 1'b0;
        n_cmp++;
        if (dut_vec() !== exp_vec() || bus.Q_Stop !== 1'b1) begin
            n_bad++;
            $display("FAIL stop_commit got=%h want=%h",
                     dut_vec(), exp_vec());
        end
        bus.pipe_idx = 2'd0;
        #1;
        frz = '{bus.Y_Out, bus.Y_Edge_O3, bus.Y_Edge_O2, bus.Y_Edge_O1};
        for (int i = 0; i < 4; i++) begin
            bus.pipe_idx = 2'((i + 1) % 4);
            cyc();
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL stop_hold%0d got=%h want=%h",
                         i, dut_vec(), exp_vec());
            end
        end
        bus.pipe_idx = 2'd0;
        #1;
        n_cmp++;
        if ({bus.Y_Out, bus.Y_Edge_O3, bus.Y_Edge_O2, bus.Y_Edge_O1} !==
            {frz[0], frz[1], frz[2], frz[3]}) begin
            n_bad++;
            $display("FAIL stop_frozen got=%0d/%0d/%0d/%0d want=%0d/%0d/%0d/%0d",
                     bus.Y_Out, bus.Y_Edge_O3, bus.Y_Edge_O2,
                     bus.Y_Edge_O1, frz[0], frz[1], frz[2], frz[3]);
        end
        bus.Ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            bus.Ack = 1'b0;
            n_cmp++;
            if (dut_vec() !== exp_vec() || bus.Q_Initial !== 1'b1) begin
                n_bad++;
                $display("FAIL stop_ack%0d got=%h want=%h",
                         i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_mid_reset();
        bus.pipe_idx = 2'd2;
        bus.Start = 1'b1;
        cyc();
        bus.Start = 1'b0;
        bus.pipe_idx = 2'd3;
        cyc();
        bus.pipe_idx = 2'd1;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        n_cmp++;
        if (dut_vec() !== exp_vec() || bus.Q_Initial !== 1'b1 ||
            bus.Regen !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_state got=%h want=%h",
                     dut_vec(), exp_vec());
        end
        bus.pipe_idx = 2'd2;
        bus.Start = 1'b1;
        cyc();
        bus.Start = 1'b0;
        cyc();
        n_cmp++;
        if (dut_vec() !== exp_vec() || bus.Regen !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_prev got=%h want=%h",
                     dut_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.Start = ($urandom_range(0, 3) == 0);
            bus.Stop = ($urandom_range(0, 40) == 0);
            bus.Ack = ($urandom_range(0, 4) == 0);
            reset = ($urandom_range(0, 150) == 0);
            case ($urandom_range(0, 5))
                0: bus.pipe_idx = 2'($urandom_range(0, 3));
                1, 2: bus.pipe_idx = bus.pipe_idx + 2'd1;
                default: bus.pipe_idx = bus.pipe_idx;
            endcase
            cyc();
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL rand_cyc%0d got=%h want=%h",
                         i, dut_vec(), exp_vec());
            end
            n_cmp++;
            if (bus.Y_Out < 10'd61 || bus.Y_Out > 10'd315) begin
                n_bad++;
                $display("FAIL rand_range%0d got=%0d want=61..315",
                         i, bus.Y_Out);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        bus.Start = 1'b0;
        bus.Stop = 1'b0;
        bus.Ack = 1'b0;
        bus.pipe_idx = 2'd2;
        @(posedge clk);
        #1;
        test_reset();
        test_regen();
        test_table_wrap();
        test_stop();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
